// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage for a multicycle RISC-V control unit. Holds the PC,
//            issues fixed-latency instruction-memory reads, buffers the
//            returned word and loads the instruction register on ir_write.
//            Register and opcode fields are decoded from the IR.
// Ports    : CLK, RST (sync, active-low)
//            fetch_req, pc_write, pc_src_sel, branch_target, ir_write  - control
//            imem_rdata, imem_addr, imem_rd_en                        - imem
//            pc, pc_plus4, instr, opcode, rd, funct3, rs1, rs2, funct7 - state/decode
//            fetch_busy, fetch_valid, misaligned_err                  - status
// Options  : IFU_MISALIGN_CHECK_EN - when defined, a fetch from a non word-
//            aligned address is not issued; a NOP is buffered instead and
//            misaligned_err is raised until that word is consumed. When
//            undefined, the low two address bits are cleared on every request.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int                DATA_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                MEM_LAT  = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               fetch_req,
  input  logic               pc_write,
  input  logic               pc_src_sel,
  input  logic [DATA_W-1:0]  branch_target,
  input  logic               ir_write,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [DATA_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  output logic [DATA_W-1:0]  pc,
  output logic [DATA_W-1:0]  pc_plus4,
  output logic [INSTR_W-1:0] instr,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [2:0]         funct3,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [6:0]         funct7,
  output logic               fetch_busy,
  output logic               fetch_valid,
  output logic               misaligned_err
);

  localparam logic [2:0]         c_LAT = 3'(MEM_LAT);
  localparam logic [INSTR_W-1:0] c_NOP = INSTR_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_fetch_addr;
  logic [INSTR_W-1:0]  r_ir;
  logic [INSTR_W-1:0]  r_buf;
  logic [2:0]          r_cnt;
  logic [DATA_W-1:0]   w_pc_plus4;
  logic [DATA_W-1:0]   w_req_addr;
  logic                w_accept;
  logic                w_ir_load;
  logic                w_misaligned;

  assign w_pc_plus4 = r_pc + DATA_W'(4);

  // A new request is taken from IDLE, or from VALID when the current word is
  // consumed in the same cycle (back-to-back fetch).
  assign w_accept  = ((r_state == S_IDLE) && fetch_req) ||
                     ((r_state == S_VALID) && ir_write && fetch_req);
  assign w_ir_load = (r_state == S_VALID) && ir_write;

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_req_addr   = r_pc;
  assign w_misaligned = (r_fetch_addr[1:0] != 2'b00);
`else
  assign w_req_addr   = {r_pc[DATA_W-1:2], 2'b00};
  assign w_misaligned = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (fetch_req) w_next = S_REQ;
      S_REQ:   w_next = w_misaligned ? S_VALID : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_next = S_VALID;
      S_VALID: if (ir_write) w_next = fetch_req ? S_REQ : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_pc         <= RESET_PC;
      r_fetch_addr <= '0;
      r_ir         <= '0;
      r_buf        <= '0;
      r_cnt        <= 3'd0;
    end else begin
      if (pc_write) begin
        r_pc <= pc_src_sel ? branch_target : w_pc_plus4;
      end
      // Latched from the pre-update PC so a same-cycle pc_write cannot
      // redirect the fetch being launched.
      if (w_accept) begin
        r_fetch_addr <= w_req_addr;
      end
      if (r_state == S_REQ) begin
        r_cnt <= c_LAT;
        if (w_misaligned) begin
          r_buf <= c_NOP;
        end
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          r_buf <= imem_rdata;
        end
      end
      if (w_ir_load) begin
        r_ir <= r_buf;
      end
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_misalign <= 1'b0;
    end else if ((r_state == S_REQ) && w_misaligned) begin
      r_misalign <= 1'b1;
    end else if (w_ir_load) begin
      r_misalign <= 1'b0;
    end
  end

  assign misaligned_err = r_misalign;
`else
  assign misaligned_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr   = r_fetch_addr;
  assign imem_rd_en  = (r_state == S_REQ) && !w_misaligned;
  assign fetch_busy  = (r_state == S_REQ) || (r_state == S_WAIT);
  assign fetch_valid = (r_state == S_VALID);
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_ir;

  // Decode strictly from the IR, never from the fetch buffer.
  assign opcode = r_ir[6:0];
  assign rd     = r_ir[11:7];
  assign funct3 = r_ir[14:12];
  assign rs1    = r_ir[19:15];
  assign rs2    = r_ir[24:20];
  assign funct7 = r_ir[31:25];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. Two instances share
//            clock, reset and PC controls: A uses MEM_LAT=1, B uses MEM_LAT=3.
//            A latency-accurate memory model feeds each instance; expected
//            read addresses and expected IR words are queued as fetches are
//            issued and retired when the DUT reads or the IR is loaded.
// Options  : honours IFU_MISALIGN_CHECK_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int         LAT_A = 1;
  localparam int         LAT_B = 3;
  localparam logic [31:0] GARB = 32'hBAD0_BAD0;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_src_sel = 1'b0;
  logic [63:0] branch_target = '0;

  logic        a_fetch_req = 1'b0, a_ir_write = 1'b0;
  logic [31:0] a_rdata = GARB;
  logic [63:0] a_addr, a_pc, a_pc4;
  logic [31:0] a_instr;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_funct3;
  logic        a_rd_en, a_busy, a_valid, a_err;

  logic        b_fetch_req = 1'b0, b_ir_write = 1'b0;
  logic [31:0] b_rdata = GARB;
  logic [63:0] b_addr, b_pc, b_pc4;
  logic [31:0] b_instr;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3;
  logic        b_rd_en, b_busy, b_valid, b_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] q_a_addr[$], q_b_addr[$];
  logic [31:0] q_a_ins[$],  q_b_ins[$];

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.MEM_LAT(LAT_A)) u_dut_a (
    .CLK(CLK), .RST(RST), .fetch_req(a_fetch_req), .pc_write(pc_write),
    .pc_src_sel(pc_src_sel), .branch_target(branch_target), .ir_write(a_ir_write),
    .imem_rdata(a_rdata), .imem_addr(a_addr), .imem_rd_en(a_rd_en), .pc(a_pc),
    .pc_plus4(a_pc4), .instr(a_instr), .opcode(a_opcode), .rd(a_rd),
    .funct3(a_funct3), .rs1(a_rs1), .rs2(a_rs2), .funct7(a_funct7),
    .fetch_busy(a_busy), .fetch_valid(a_valid), .misaligned_err(a_err)
  );

  instr_fetch_unit #(.MEM_LAT(LAT_B)) u_dut_b (
    .CLK(CLK), .RST(RST), .fetch_req(b_fetch_req), .pc_write(pc_write),
    .pc_src_sel(pc_src_sel), .branch_target(branch_target), .ir_write(b_ir_write),
    .imem_rdata(b_rdata), .imem_addr(b_addr), .imem_rd_en(b_rd_en), .pc(b_pc),
    .pc_plus4(b_pc4), .instr(b_instr), .opcode(b_opcode), .rd(b_rd),
    .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2), .funct7(b_funct7),
    .fetch_busy(b_busy), .fetch_valid(b_valid), .misaligned_err(b_err)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    return 32'h0050_0093 + (a[31:0] << 7);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_ins_a;
    if (q_a_ins.size() == 0) chk("a_ins_queue_empty", 1, 0);
    else chk("a_instr", {32'h0, a_instr}, {32'h0, q_a_ins.pop_front()});
  endtask

  task automatic chk_ins_b;
    if (q_b_ins.size() == 0) chk("b_ins_queue_empty", 1, 0);
    else chk("b_instr", {32'h0, b_instr}, {32'h0, q_b_ins.pop_front()});
  endtask

  // Memory models: data is presented only in the last cycle of the latency
  // window following a read strobe; garbage otherwise.
  int          ka = 0, kb = 0;
  logic [63:0] aq = '0, bq = '0;

  always @(negedge CLK) begin
    if (ka > 0) begin
      a_rdata = (ka == 1) ? mem(aq) : GARB;
      ka--;
    end else a_rdata = GARB;
    if (a_rd_en) begin
      ka = LAT_A;
      aq = a_addr;
    end
  end

  always @(negedge CLK) begin
    if (kb > 0) begin
      b_rdata = (kb == 1) ? mem(bq) : GARB;
      kb--;
    end else b_rdata = GARB;
    if (b_rd_en) begin
      kb = LAT_B;
      bq = b_addr;
    end
  end

  // Read-strobe scoreboards: every strobe must match a queued expected fetch.
  always @(negedge CLK) begin
    if (a_rd_en) begin
      if (q_a_addr.size() == 0) chk("a_rd_en_unexpected", 1, 0);
      else chk("a_imem_addr", a_addr, q_a_addr.pop_front());
    end
    if (b_rd_en) begin
      if (q_b_addr.size() == 0) chk("b_rd_en_unexpected", 1, 0);
      else chk("b_imem_addr", b_addr, q_b_addr.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic        sel;
    logic [63:0] tgt;
    logic [63:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vec[7];

  initial begin
    int n;

    vec[0] = '{1'b1, 1'b0, 64'h0,                    64'h4};
    vec[1] = '{1'b1, 1'b0, 64'h0,                    64'h8};
    vec[2] = '{1'b1, 1'b0, 64'h0,                    64'hC};
    vec[3] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,  64'hFFFF_FFFF_FFFF_FFFC};
    vec[4] = '{1'b1, 1'b0, 64'h0,                    64'h0};
    vec[5] = '{1'b0, 1'b1, 64'h55,                   64'h0};
    vec[6] = '{1'b1, 1'b1, 64'h40,                   64'h40};

    // ---------------- reset state ----------------
    RST = 1'b0;
    tick; tick;
    chk("rst_pc", a_pc, 64'h0);
    chk("rst_instr", {32'h0, a_instr}, 64'h0);
    chk("rst_addr", a_addr, 64'h0);
    chk("rst_rd_en", {63'h0, a_rd_en}, 64'h0);
    chk("rst_busy", {63'h0, a_busy}, 64'h0);
    chk("rst_valid", {63'h0, a_valid}, 64'h0);
    chk("rst_err", {63'h0, a_err}, 64'h0);
    RST = 1'b1;
    tick;

    // ---------------- basic fetch, MEM_LAT=1 ----------------
    a_fetch_req = 1'b1;
    q_a_addr.push_back(64'h0);
    q_a_ins.push_back(mem(64'h0));
    tick;
    a_fetch_req = 1'b0;
    chk("t1_rd_en", {63'h0, a_rd_en}, 64'h1);
    chk("t1_busy_req", {63'h0, a_busy}, 64'h1);
    tick;
    chk("t1_rd_en_off", {63'h0, a_rd_en}, 64'h0);
    chk("t1_busy_wait", {63'h0, a_busy}, 64'h1);
    chk("t1_valid_early", {63'h0, a_valid}, 64'h0);
    tick;
    chk("t1_valid", {63'h0, a_valid}, 64'h1);
    chk("t1_busy_off", {63'h0, a_busy}, 64'h0);
    chk("t1_ir_not_buf", {32'h0, a_instr}, 64'h0);
    a_ir_write = 1'b1;
    tick;
    a_ir_write = 1'b0;
    chk_ins_a;
    chk("t1_opcode", {57'h0, a_opcode}, 64'h13);
    chk("t1_rd", {59'h0, a_rd}, 64'h1);
    chk("t1_rs1", {59'h0, a_rs1}, 64'h0);
    chk("t1_rs2", {59'h0, a_rs2}, 64'h5);
    chk("t1_funct3", {61'h0, a_funct3}, 64'h0);
    chk("t1_funct7", {57'h0, a_funct7}, 64'h0);
    chk("t1_idle", {63'h0, a_valid}, 64'h0);

    // ---------------- PC update vectors ----------------
    for (int i = 0; i < 7; i++) begin
      pc_write      = vec[i].we;
      pc_src_sel    = vec[i].sel;
      branch_target = vec[i].tgt;
      tick;
      pc_write = 1'b0;
      chk($sformatf("vec%0d_pc", i), a_pc, vec[i].exp_pc);
      chk($sformatf("vec%0d_pc4", i), a_pc4, vec[i].exp_pc + 64'd4);
      chk($sformatf("vec%0d_pc_b", i), b_pc, vec[i].exp_pc);
    end

    // ---------------- back-to-back + ignored requests ----------------
    a_fetch_req = 1'b1;
    q_a_addr.push_back(64'h40);
    q_a_ins.push_back(mem(64'h40));
    tick;                      // REQ, fetch_req held high
    tick;                      // WAIT, fetch_req held high
    tick;                      // VALID
    chk("b2b_valid", {63'h0, a_valid}, 64'h1);
    tick;                      // fetch_req without ir_write: ignored
    chk("b2b_hold_valid", {63'h0, a_valid}, 64'h1);
    chk("b2b_hold_busy", {63'h0, a_busy}, 64'h0);
    a_ir_write = 1'b1;
    q_a_addr.push_back(64'h40);
    q_a_ins.push_back(mem(64'h40));
    tick;
    a_ir_write  = 1'b0;
    a_fetch_req = 1'b0;
    chk_ins_a;
    chk("b2b_rd_en", {63'h0, a_rd_en}, 64'h1);
    tick; tick;
    chk("b2b_valid2", {63'h0, a_valid}, 64'h1);
    a_ir_write = 1'b1;
    tick;
    a_ir_write = 1'b0;
    chk_ins_a;

    // ---------------- alignment handling ----------------
    pc_write = 1'b1; pc_src_sel = 1'b1; branch_target = 64'h102;
    tick;
    pc_write = 1'b0;
    chk("mis_pc", a_pc, 64'h102);
`ifdef IFU_MISALIGN_CHECK_EN
    a_fetch_req = 1'b1;
    q_a_ins.push_back(32'h0000_0013);
    tick;
    a_fetch_req = 1'b0;
    chk("mis_no_rd_en", {63'h0, a_rd_en}, 64'h0);
    chk("mis_addr", a_addr, 64'h102);
    tick;
    chk("mis_valid", {63'h0, a_valid}, 64'h1);
    chk("mis_err", {63'h0, a_err}, 64'h1);
    a_ir_write = 1'b1;
    tick;
    a_ir_write = 1'b0;
    chk_ins_a;
    chk("mis_err_clr", {63'h0, a_err}, 64'h0);
`else
    a_fetch_req = 1'b1;
    q_a_addr.push_back(64'h100);
    q_a_ins.push_back(mem(64'h100));
    tick;
    a_fetch_req = 1'b0;
    chk("align_addr", a_addr, 64'h100);
    chk("align_rd_en", {63'h0, a_rd_en}, 64'h1);
    tick; tick;
    chk("align_valid", {63'h0, a_valid}, 64'h1);
    chk("align_err", {63'h0, a_err}, 64'h0);
    a_ir_write = 1'b1;
    tick;
    a_ir_write = 1'b0;
    chk_ins_a;
`endif

    // ---------------- MEM_LAT=3, pc_write during REQ ----------------
    RST = 1'b0;
    tick; tick;
    RST = 1'b1;
    chk("b_rst_pc", b_pc, 64'h0);
    b_fetch_req = 1'b1;
    q_b_addr.push_back(64'h0);
    q_b_ins.push_back(mem(64'h0));
    tick;
    b_fetch_req = 1'b0;
    pc_write = 1'b1; pc_src_sel = 1'b1; branch_target = 64'h100;
    chk("b_rd_en", {63'h0, b_rd_en}, 64'h1);
    tick;
    pc_write = 1'b0;
    chk("b_addr_hold", b_addr, 64'h0);
    chk("b_pc_new", b_pc, 64'h100);
    chk("b_busy", {63'h0, b_busy}, 64'h1);
    n = 2;
    while (!b_valid && n < 20) begin
      tick;
      n++;
    end
    chk("b_latency", 64'(n), 64'd5);
    b_ir_write = 1'b1;
    tick;
    b_ir_write = 1'b0;
    chk_ins_b;

    // ---------------- reset during WAIT ----------------
    b_fetch_req = 1'b1;
    q_b_addr.push_back(64'h100);
    tick;
    b_fetch_req = 1'b0;
    tick;                      // first WAIT cycle
    RST = 1'b0;
    tick;
    RST = 1'b1;
    chk("rw_valid", {63'h0, b_valid}, 64'h0);
    chk("rw_busy", {63'h0, b_busy}, 64'h0);
    chk("rw_pc", b_pc, 64'h0);
    chk("rw_addr", b_addr, 64'h0);
    tick; tick; tick; tick;
    chk("rw_late_valid", {63'h0, b_valid}, 64'h0);
    b_ir_write = 1'b1;
    tick;
    b_ir_write = 1'b0;
    chk("rw_instr", {32'h0, b_instr}, 64'h0);

    // ---------------- drain scoreboards ----------------
    tick;
    chk("q_a_addr_left", 64'(q_a_addr.size()), 64'd0);
    chk("q_b_addr_left", 64'(q_b_addr.size()), 64'd0);
    chk("q_a_ins_left", 64'(q_a_ins.size()), 64'd0);
    chk("q_b_ins_left", 64'(q_b_ins.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
